// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the FIFO-fed UART transmitter.
//   uart_state_e : transmitter FSM state encoding (3 bits)
//   frame_clks() : clocks per complete frame for a given configuration
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_state_e;

  // Start bit + data bits + optional parity bit + stop bits, in clocks.
  function automatic int unsigned frame_clks(input int unsigned data_width,
                                             input int unsigned parity_en,
                                             input int unsigned stop_bits,
                                             input int unsigned clks_per_bit);
    return clks_per_bit * (1 + data_width + parity_en + stop_bits);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter for the UART transmitter.
//   clk, rst     : clock, synchronous active-high reset
//   restart      : synchronous restart; counter is 0 in the following cycle
//   bit_end      : high in the last cycle of each bit period
//   bit_pre_end  : high in the next-to-last cycle of each bit period
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end     = (cnt_q == LAST);
  assign bit_pre_end = (cnt_q == PRE_LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || bit_end) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a word FIFO and serialises each word as a UART frame
// (start bit, data LSB first, optional even parity, 1 or 2 stop bits).
//   clk, rst    : clock, synchronous active-high reset
//   tx_enable   : permits new frames to start (never aborts one in flight)
//   fifo_empty  : FIFO empty flag
//   fifo_data   : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  : one-cycle FIFO pop per frame
//   tx          : serial line, idles high
//   busy        : FSM not idle
//   frame_done  : pulse in the last cycle of the final stop bit
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  frame_done_q, frame_done_d;
  logic                  restart, bit_end, bit_pre_end;

  // Every state change restarts the bit period so each state begins at count 0.
  assign restart = (state_d != state_q);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk         (clk),
    .rst         (rst),
    .restart     (restart),
    .bit_end     (bit_end),
    .bit_pre_end (bit_pre_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    case (state_q)
      ST_IDLE:  if (tx_enable && !fifo_empty) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        shift_d  = fifo_data;
        parity_d = ^fifo_data;
        state_d  = ST_START;
      end
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == DATA_LAST) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == STOP_LAST) state_d = (tx_enable && !fifo_empty) ? ST_FETCH : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The bit counter serves both DATA and STOP, so it restarts on every entry.
    if (state_d != state_q) bit_cnt_d = '0;

    // Outputs are registered from next-state values so they align with the state.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
    rd_en_d = (state_d == ST_FETCH);
    // Next cycle is the last one of the final stop bit.
    frame_done_d = (state_q == ST_STOP) && (bit_cnt_q == STOP_LAST) && bit_pre_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
      rd_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      rd_en_q      <= rd_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd_en = rd_en_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: self-checking bench. Two DUTs share the clock:
//   A: 8 data bits, 4 clocks/bit, no parity, 1 stop bit
//   B: 8 data bits, 4 clocks/bit, even parity, 2 stop bits
// Each has a behavioural FIFO; expected frames are built from the word value.
module tb_fifo_uart_tx;
  import uart_pkg::*;

  localparam int unsigned C = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b1, en_b = 1'b1;
  logic empty_a, empty_b;
  logic [7:0] data_a = '0, data_b = '0;
  logic rd_en_a, rd_en_b, tx_a, tx_b, busy_a, busy_b, fd_a, fd_b;

  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];
  int unsigned wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  int unsigned rdc_a = 0, fdc_a = 0;
  int unsigned n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst(rst), .tx_enable(en_a), .fifo_empty(empty_a), .fifo_data(data_a),
    .fifo_rd_en(rd_en_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a));

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .tx_enable(en_b), .fifo_empty(empty_b), .fifo_data(data_b),
    .fifo_rd_en(rd_en_b), .tx(tx_b), .busy(busy_b), .frame_done(fd_b));

  // Behavioural FIFOs: a sampled rd_en pops, data appears the next cycle.
  assign empty_a = (wr_a == rd_a);
  assign empty_b = (wr_b == rd_b);

  always @(posedge clk) begin
    if (rd_en_a && wr_a != rd_a) begin
      data_a <= mem_a[rd_a % 256];
      rd_a   <= rd_a + 1;
    end
    if (rd_en_b && wr_b != rd_b) begin
      data_b <= mem_b[rd_b % 256];
      rd_b   <= rd_b + 1;
    end
  end

  always @(negedge clk) begin
    if (rd_en_a) rdc_a <= rdc_a + 1;
    if (fd_a)    fdc_a <= fdc_a + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic tx_of(input bit ins);
    return ins ? tx_b : tx_a;
  endfunction
  function automatic logic busy_of(input bit ins);
    return ins ? busy_b : busy_a;
  endfunction
  function automatic logic fd_of(input bit ins);
    return ins ? fd_b : fd_a;
  endfunction

  task automatic push(input bit ins, input logic [7:0] w);
    if (ins) begin
      mem_b[wr_b % 256] = w;
      wr_b = wr_b + 1;
    end else begin
      mem_a[wr_a % 256] = w;
      wr_a = wr_a + 1;
    end
  endtask

  // Waits for the start bit, then checks every cycle of the frame against the
  // bit sequence derived from w. Reports idle-high cycles seen before the start
  // bit and how many of them had busy low. drop_at != 0 drops en_a at that cycle.
  task automatic expect_frame(input bit ins, input logic [7:0] w, input int unsigned pe,
                              input int unsigned sb, input int unsigned drop_at,
                              output int unsigned high_cycles, output int unsigned busy_low);
    int unsigned total, nb, waited;
    logic exp_bits [0:15];
    total = frame_clks(8, pe, sb, C);
    nb = 0;
    exp_bits[nb] = 1'b0; nb++;
    for (int i = 0; i < 8; i++) begin exp_bits[nb] = w[i]; nb++; end
    if (pe != 0) begin exp_bits[nb] = ^w; nb++; end
    for (int i = 0; i < int'(sb); i++) begin exp_bits[nb] = 1'b1; nb++; end
    high_cycles = 0;
    busy_low = 0;
    waited = 0;
    @(negedge clk);
    while (tx_of(ins) !== 1'b0 && waited < 200) begin
      if (busy_of(ins) !== 1'b1) busy_low++;
      high_cycles++;
      waited++;
      @(negedge clk);
    end
    if (waited >= 200) begin
      check_eq("start_timeout", tx_of(ins), 0);
      return;
    end
    for (int unsigned k = 0; k < total; k++) begin
      if (k != 0) @(negedge clk);
      if (drop_at != 0 && k == drop_at) en_a = 1'b0;
      check_eq("tx_bit", tx_of(ins), exp_bits[k / C]);
      check_eq("busy_in_frame", busy_of(ins), 1);
      check_eq("frame_done", fd_of(ins), (k == total - 1));
    end
  endtask

  task automatic expect_idle(input bit ins);
    @(negedge clk);
    check_eq("idle_busy", busy_of(ins), 0);
    check_eq("idle_tx", tx_of(ins), 1);
  endtask

  task automatic frame_gap(input bit ins, input logic [7:0] w, input int unsigned pe,
                           input int unsigned sb);
    int unsigned hc, bl;
    expect_frame(ins, w, pe, sb, 0, hc, bl);
    check_eq("gap_high_cycles", hc, 2);
    check_eq("gap_busy_low", bl, 0);
  endtask

  initial begin
    int unsigned r0, f0, r1, waited, n;
    logic [7:0] w [0:7];

    // Reset held with data queued and enable high.
    push(0, 8'h55);
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_tx", tx_a, 1);
      check_eq("rst_rd_en", rd_en_a, 0);
      check_eq("rst_busy", busy_a, 0);
      check_eq("rst_frame_done", fd_a, 0);
      check_eq("rst_tx_b", tx_b, 1);
    end
    r0 = rdc_a;
    f0 = fdc_a;
    rst = 1'b0;

    // Single frame 0x55.
    frame_gap(0, 8'h55, 0, 1);
    expect_idle(0);
    check_eq("single_rd_pulses", rdc_a - r0, 1);
    check_eq("single_frame_done", fdc_a - f0, 1);

    // Back-to-back frames.
    repeat ($urandom_range(0, 4)) @(negedge clk);
    r0 = rdc_a;
    f0 = fdc_a;
    push(0, 8'd22); push(0, 8'd23); push(0, 8'd24);
    frame_gap(0, 8'h16, 0, 1);
    frame_gap(0, 8'h17, 0, 1);
    frame_gap(0, 8'h18, 0, 1);
    expect_idle(0);
    check_eq("b2b_rd_pulses", rdc_a - r0, 3);
    check_eq("b2b_frame_done", fdc_a - f0, 3);

    // Parity with two stop bits, then a random word on the same DUT.
    push(1, 8'h07);
    frame_gap(1, 8'h07, 1, 2);
    expect_idle(1);
    w[0] = 8'($urandom);
    push(1, w[0]);
    frame_gap(1, w[0], 1, 2);
    expect_idle(1);

    // Enable dropped during the data bits with two words still queued.
    for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
    r0 = rdc_a;
    for (int i = 0; i < 3; i++) push(0, w[i]);
    begin
      int unsigned hc, bl;
      expect_frame(0, w[0], 0, 1, 2 * C, hc, bl);
      check_eq("en_first_gap", hc, 2);
    end
    r1 = rdc_a;
    check_eq("en_first_rd", r1 - r0, 1);
    repeat (20) begin
      @(negedge clk);
      check_eq("disabled_tx", tx_a, 1);
      check_eq("disabled_busy", busy_a, 0);
      check_eq("disabled_rd_en", rd_en_a, 0);
    end
    check_eq("disabled_rd_pulses", rdc_a, r1);
    en_a = 1'b1;
    frame_gap(0, w[1], 0, 1);
    frame_gap(0, w[2], 0, 1);
    expect_idle(0);

    // Reset during the third data bit discards the in-flight word.
    for (int i = 3; i < 5; i++) w[i] = 8'($urandom);
    f0 = fdc_a;
    push(0, w[3]);
    push(0, w[4]);
    waited = 0;
    @(negedge clk);
    while (tx_a !== 1'b0 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    check_eq("abort_start_seen", tx_a, 0);
    repeat (3 * C + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_tx", tx_a, 1);
    check_eq("abort_busy", busy_a, 0);
    check_eq("abort_frame_done", fd_a, 0);
    rst = 1'b0;
    check_eq("abort_no_done_pulse", fdc_a, f0);
    frame_gap(0, w[4], 0, 1);
    expect_idle(0);

    // Random back-to-back burst.
    n = $urandom_range(3, 6);
    r0 = rdc_a;
    for (int unsigned i = 0; i < n; i++) begin
      w[i] = 8'($urandom);
      push(0, w[i]);
    end
    for (int unsigned i = 0; i < n; i++) frame_gap(0, w[i], 0, 1);
    expect_idle(0);
    check_eq("burst_rd_pulses", rdc_a - r0, n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
